// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the bit-serial adder.
//   state_t : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   clog2   : ceiling log2, used to size the bit counter
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Smallest r with 2**r >= n (returns 0 for n <= 1).
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      longint unsigned v;
      r = 0;
      v = 1;
      while (v < longint'(n)) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake plus operand and result bus.
//   master : upstream controller (drives start, a, b, cin)
//   slave  : adder (drives busy, done, sum, cout, ovf)
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational one-bit full adder.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one bit per clock through a single
// full-adder cell with a registered carry. Result is a + b + cin.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : serial_adder_if slave (start/a/b/cin in; busy/done/sum/cout/ovf out)
// Build option: define SERIAL_ADDER_OVF_EN to build the signed-overflow flag;
// otherwise ovf is tied to 0.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input logic          clk,
   input logic          rst_n,
   serial_adder_if.slave bus
);
   localparam int unsigned CNT_W = clog2(WIDTH + 1);

   state_t state_q, state_nxt;
   logic   accept_c, shift_c, last_c;

   logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q, done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             fa_s, fa_co;

   // Single full-adder cell fed from the LSBs and the running carry.
   fa_cell u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // New sum bit enters at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
   always_comb begin
      sum_nxt            = sum_sh >> 1;
      sum_nxt[WIDTH-1]   = fa_s;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   // Next-state and datapath strobes.
   always_comb begin
      state_nxt = state_q;
      accept_c  = 1'b0;
      shift_c   = 1'b0;
      last_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               accept_c  = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            shift_c = 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               last_c    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.start) begin
               accept_c  = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= (state_nxt == RUN);
         done_q <= (state_nxt == DONE);
      end
   end

   // Operand shifters, carry, counter and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         if (accept_c) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
         end else if (shift_c) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            sum_sh  <= sum_nxt;
            carry_q <= fa_co;
            cnt_q   <= cnt_q + CNT_W'(1);
         end
         if (last_c) begin
            sum_q  <= sum_nxt;
            cout_q <= fa_co;
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q;

   // On the last bit carry_q is the carry into the MSB and fa_co the carry out.
   always_ff @(posedge clk) begin
      if (!rst_n)      ovf_q <= 1'b0;
      else if (last_c) ovf_q <= carry_q ^ fa_co;
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial ripple adder: adds two WIDTH-bit operands plus carry-in, one bit per clock, through a single full-adder cell and a registered carry. It is the sequential successor to the team's one-bit full adder. It serves area-constrained datapaths that can trade latency for gates, and gives a start/busy/done handshake to an upstream controller.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..64
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when the block is not busy
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when result becomes valid
- sum  output  WIDTH  registered result, LSB computed first
- cout  output  1  final carry-out
- ovf  output  1  signed (two's-complement) overflow flag

## Operation
- Reset: one clock, synchronous, active-low; fixed by design.
- States: IDLE, RUN, DONE. Two-bit state register.
- IDLE: busy=0, done=0. start=1 -> capture a, b, cin into shift registers and carry register; clear bit counter; go to RUN.
- RUN: busy=1. Each cycle the fa_cell adds a_sh[0], b_sh[0] and carry_q. The sum bit shifts into the MSB of the sum shift register. carry_q takes the cell carry. a_sh and b_sh shift right and the counter increments. After WIDTH RUN cycles, go to DONE.
- DONE: busy=0, done=1 for exactly one cycle. sum, cout and ovf outputs load from the internal shift/carry registers at the RUN->DONE edge. If start=1 in DONE, it is accepted (back-to-back) and the block goes to RUN; otherwise it goes to IDLE.
- start is ignored while busy=1. No queueing.
- sum, cout and ovf hold their last result until the next completion. They do not change during RUN.
- Width rules: the counter is ceil(log2(WIDTH+1)) bits. Arithmetic is modulo 2^WIDTH. cout is bit WIDTH of a+b+cin.
- ovf = carry into the MSB XOR carry out of the MSB. It is captured during the last RUN cycle. For WIDTH=1, ovf = cin XOR cout.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state=IDLE, counter=0.
- Latency: start accepted at edge k gives busy=1 in cycles k+1..k+WIDTH, and done=1 with a valid result in cycle k+WIDTH+1.
- Throughput: one addition per WIDTH+1 cycles with back-to-back start.
- Reset asserted mid-RUN: the operation is aborted at the next edge. No done pulse. All outputs return to reset values.
- Reset has priority over start on the same edge.

## Configuration
- SERIAL_ADDER_OVF_EN defined: the MSB carry-in tap and ovf register are built, and ovf behaves as specified above.
- SERIAL_ADDER_OVF_EN undefined: the ovf port remains present but is tied to 0, and no overflow logic is synthesised.

## Structure
- Shared package serial_adder_pkg holds:
  - the state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - the counter-width function clog2
- Sub-module fa_cell: combinational one-bit full adder (a, b, ci -> s, co), instantiated once.

## Test plan
- WIDTH=8, a=0x00, b=0x00, cin=0, start at edge k -> done only in cycle k+9; sum=0x00, cout=0, ovf=0; busy high exactly 8 cycles.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1 (ovf=0 when the macro is undefined).
- WIDTH=8, a=0x12, b=0x34 in flight; start with a=0xFF pulsed mid-RUN -> ignored, result 0x46. Back-to-back start in the DONE cycle with 0x01+0x01 -> 0x02 after a further 9 cycles.
- WIDTH=8, rst_n low for one cycle at RUN cycle 4 -> no done pulse; sum/cout/ovf/busy=0 on the next cycle; a subsequent 0x05+0x03 gives 0x08.
- WIDTH=4, exhaustive sweep of all 512 (a, b, cin) combinations -> {cout, sum} == a+b+cin, and ovf matches the signed reference for each.
- WIDTH=1, a=1, b=1, cin=1 -> sum=1, cout=1, done 2 cycles after start.
